// File: rtl/ones_counter_seq.sv
// Sequential population counter: latches a W-bit operand on start and sums
// its ones (or in-range zeros) K bits per clock, pulsing done with the total.
module ones_counter_seq #(
  parameter int W = 127,
  parameter int K = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [W-1:0]           A,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(W+1)-1:0] N
);

  localparam int NW = $clog2(W + 1);
  localparam int C  = (W + K - 1) / K;
  localparam int PW = C * K;
  localparam int KW = $clog2(K + 1);
  localparam int CW = (C > 1) ? $clog2(C) : 1;

  // Marks the W real operand bits; padding above W is never counted.
  localparam logic [PW-1:0] IN_RANGE = PW'({W{1'b1}});
  localparam logic [CW-1:0] LAST_IDX = CW'(C - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [PW-1:0]  sr_r;
  logic [PW-1:0]  vm_r;
  logic           mode_r;
  logic [NW-1:0]  acc_r;
  logic [CW-1:0]  idx_r;
  logic           busy_r;
  logic           done_r;
  logic [NW-1:0]  n_r;

  logic [K-1:0]   chunk_s;
  logic [K-1:0]   mask_s;
  logic [K-1:0]   sel_s;
  logic [KW-1:0]  pc_s;
  logic [NW-1:0]  sum_s;
  logic           last_s;

  function automatic logic [KW-1:0] popcount(input logic [K-1:0] v);
    logic [KW-1:0] c;
    c = {KW{1'b0}};
    for (int i = 0; i < K; i++) begin
      c = c + KW'(v[i]);
    end
    return c;
  endfunction

  // Per-chunk datapath: select counted bits, popcount, add to running total.
  always_comb begin
    chunk_s = sr_r[K-1:0];
    mask_s  = vm_r[K-1:0];
    if (mode_r) begin
      sel_s = ~chunk_s & mask_s;
    end else begin
      sel_s = chunk_s & mask_s;
    end
    pc_s   = popcount(sel_s);
    sum_s  = acc_r + NW'(pc_s);
    last_s = (idx_r == LAST_IDX);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = COUNT;
        end else begin
          state_s = IDLE;
        end
      end
      COUNT: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = COUNT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand/mask shifters, accumulator and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r   <= {PW{1'b0}};
      vm_r   <= {PW{1'b0}};
      mode_r <= 1'b0;
      acc_r  <= {NW{1'b0}};
      idx_r  <= {CW{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
      n_r    <= {NW{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            sr_r   <= PW'(A);
            vm_r   <= IN_RANGE;
            mode_r <= mode;
            acc_r  <= {NW{1'b0}};
            idx_r  <= {CW{1'b0}};
            n_r    <= {NW{1'b0}};
            busy_r <= 1'b1;
          end
        end
        COUNT: begin
          acc_r <= sum_s;
          sr_r  <= sr_r >> K;
          vm_r  <= vm_r >> K;
          idx_r <= idx_r + CW'(1);
          if (last_s) begin
            n_r    <= sum_s;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign N    = n_r;

endmodule
